// File: rtl/line_fill_memory.sv
// Shared line-fill backing store for the instruction and data caches.
// One array of 128-bit lines sits behind a round-robin arbiter. Each granted
// transaction spends LATENCY cycles in ACCESS, then pulses the owning port's
// valid for one RESPOND cycle while its registered line output shows the data.
// Data-port word writes are read-modify-write: the line is fetched at grant,
// the word is merged in, and the merged line is committed on the last ACCESS edge.
module line_fill_memory #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic         i_valid,
  output logic [127:0] i_line,
  input  logic         d_req,
  input  logic [31:0]  d_addr,
  input  logic         d_write,
  input  logic [31:0]  d_wdata,
  output logic         d_valid,
  output logic [127:0] d_line,
  output logic         busy
);

  localparam int         IDX_W     = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam logic [3:0] LAST_CNT  = 4'(LATENCY - 1);
  localparam logic       SRC_INSTR = 1'b0;
  localparam logic       SRC_DATA  = 1'b1;

  // Parameter sanity: refuse to elaborate an unsupported configuration.
  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("line_fill_memory: LATENCY must be in 1..15");
    end
    if (DEPTH_LINES < 2 || (DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_bad_depth
      $error("line_fill_memory: DEPTH_LINES must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]       cnt_reg;
  logic             last_grant_reg;   // source granted most recently
  logic             src_reg;          // source owning the current transaction
  logic             write_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [1:0]       word_reg;
  logic [31:0]      wdata_reg;

  logic [127:0]     mem [DEPTH_LINES];
  logic [127:0]     rd_line_reg;
  logic [127:0]     merged_line;
  logic [127:0]     resp_line;

  logic             i_valid_reg, d_valid_reg;
  logic [127:0]     i_line_reg, d_line_reg;

  logic             grant_valid;
  logic             grant_data;
  logic [IDX_W-1:0] grant_idx;
  logic             commit;

  // Address bits that never select anything; kept visible so lint stays quiet.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:IDX_W+4], i_addr[3:0],
                              d_addr[31:IDX_W+4], d_addr[1:0]};

  // Round-robin choice: a lone request wins, a tie goes to the other source.
  always_comb begin
    grant_data = d_req && (!i_req || (last_grant_reg == SRC_INSTR));
    grant_idx  = grant_data ? d_addr[IDX_W+3:4] : i_addr[IDX_W+3:4];
  end

  // Replace the addressed word of the fetched line with the write data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_line[32*gi +: 32] = (word_reg == 2'(gi)) ? wdata_reg
                                                             : rd_line_reg[32*gi +: 32];
    end
  endgenerate

  assign resp_line = write_reg ? merged_line : rd_line_reg;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the grant and commit strobes.
  always_comb begin
    state_next  = state_reg;
    grant_valid = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant_valid = 1'b1;
          state_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == LAST_CNT) begin
          commit     = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the granted request and run the access counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg        <= 4'd0;
      last_grant_reg <= SRC_INSTR;
      src_reg        <= SRC_INSTR;
      write_reg      <= 1'b0;
      idx_reg        <= '0;
      word_reg       <= 2'd0;
      wdata_reg      <= 32'd0;
    end else if (grant_valid) begin
      cnt_reg        <= 4'd0;
      last_grant_reg <= grant_data;
      src_reg        <= grant_data;
      write_reg      <= grant_data && d_write;
      idx_reg        <= grant_idx;
      word_reg       <= d_addr[3:2];
      wdata_reg      <= d_wdata;
    end else if (state_reg == ACCESS) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  // Line array: registered read at grant, merged-line write on commit.
  // Commit only happens in ACCESS, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (commit && write_reg) begin
      mem[idx_reg] <= merged_line;
    end
    if (grant_valid) begin
      rd_line_reg <= mem[grant_idx];
    end
  end

  // Response registers: pulse the owner's valid and hold each port's last line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_valid_reg <= 1'b0;
      d_valid_reg <= 1'b0;
      i_line_reg  <= 128'd0;
      d_line_reg  <= 128'd0;
    end else begin
      i_valid_reg <= commit && (src_reg == SRC_INSTR);
      d_valid_reg <= commit && (src_reg == SRC_DATA);
      if (commit && (src_reg == SRC_INSTR)) begin
        i_line_reg <= resp_line;
      end
      if (commit && (src_reg == SRC_DATA)) begin
        d_line_reg <= resp_line;
      end
    end
  end

  assign i_valid = i_valid_reg;
  assign d_valid = d_valid_reg;
  assign i_line  = i_line_reg;
  assign d_line  = d_line_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_line_fill_memory.sv
// Randomised bench for line_fill_memory with a line-level reference model.
module tb_line_fill_memory;

  localparam int DEPTH   = 256;
  localparam int LAT     = 4;
  localparam int T_FIRST = LAT + 1;       // pulse cycle of a transaction granted at edge 0
  localparam int T_SEC   = 2 * LAT + 3;   // pulse cycle of the loser of a tie

  logic         clk;
  logic         rstn;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_valid;
  logic [127:0] i_line;
  logic         d_req;
  logic [31:0]  d_addr;
  logic         d_write;
  logic [31:0]  d_wdata;
  logic         d_valid;
  logic [127:0] d_line;
  logic         busy;

  line_fill_memory #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_valid (i_valid),
    .i_line  (i_line),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_write (d_write),
    .d_wdata (d_wdata),
    .d_valid (d_valid),
    .d_line  (d_line),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: array contents, last granted source, held line outputs.
  logic [127:0] m_mem [DEPTH];
  bit           m_last_data;
  logic [127:0] m_i_line;
  logic [127:0] m_d_line;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    logic [31:0] ln;
    r  = $urandom();
    ln = $urandom_range(0, 15);
    return (r & 32'hFFFF_F00F) | (ln << 4);
  endfunction

  // Model of one access: returns the line the port should see.
  function automatic logic [127:0] model_access(input logic [31:0] a, input bit wr,
                                                input logic [31:0] wd);
    logic [127:0] ln;
    ln = m_mem[line_of(a)];
    if (wr) begin
      ln[32*word_of(a) +: 32] = wd;
      m_mem[line_of(a)] = ln;
    end
    return ln;
  endfunction

  task automatic model_reset();
    m_last_data = 1'b0;
    m_i_line    = 128'd0;
    m_d_line    = 128'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    check({tag, "_ival"}, {127'd0, i_valid}, 128'd0);
    check({tag, "_dval"}, {127'd0, d_valid}, 128'd0);
    check({tag, "_iline"}, i_line, 128'd0);
    check({tag, "_dline"}, d_line, 128'd0);
  endtask

  // Called at a negedge; leaves the bench at a negedge with rstn released.
  task automatic do_reset();
    rstn  = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    $display("txn reset");
  endtask

  // One transaction (or a tie of two), driven at a negedge = cycle 0.
  task automatic issue(input bit ui, input bit ud, input logic [31:0] ia,
                       input logic [31:0] da, input bit dw, input logic [31:0] wd,
                       input bit scramble);
    int t_i;
    int t_d;
    int last_cyc;
    bit data_first;
    bit both;
    bit exp_busy;
    logic [127:0] exp_i;
    logic [127:0] exp_d;
    both       = ui && ud;
    data_first = ud && (!ui || !m_last_data);
    exp_i      = 128'd0;
    exp_d      = 128'd0;
    t_i        = 0;
    t_d        = 0;
    if (data_first) begin
      exp_d = model_access(da, dw, wd);
      t_d   = T_FIRST;
      if (ui) begin
        exp_i = model_access(ia, 1'b0, 32'd0);
        t_i   = T_SEC;
      end
    end else begin
      exp_i = model_access(ia, 1'b0, 32'd0);
      t_i   = T_FIRST;
      if (ud) begin
        exp_d = model_access(da, dw, wd);
        t_d   = T_SEC;
      end
    end
    m_last_data = both ? !data_first : ud;
    if (ui) m_i_line = exp_i;
    if (ud) m_d_line = exp_d;
    last_cyc = both ? T_SEC + 1 : T_FIRST + 1;

    i_req   = ui;
    i_addr  = ia;
    d_req   = ud;
    d_addr  = da;
    d_write = dw;
    d_wdata = wd;
    for (int c = 1; c <= last_cyc; c++) begin
      @(negedge clk);
      exp_busy = (c <= T_FIRST) || (both && c >= T_FIRST + 2 && c <= T_SEC);
      check("busy", {127'd0, busy}, {127'd0, exp_busy});
      check("i_valid", {127'd0, i_valid}, {127'd0, (c == t_i)});
      check("d_valid", {127'd0, d_valid}, {127'd0, (c == t_d)});
      if (c == t_i) begin
        check("i_line", i_line, exp_i);
        i_req = 1'b0;
      end
      if (c == t_d) begin
        check("d_line", d_line, exp_d);
        d_req = 1'b0;
      end
      if (scramble && !both && c == 1) begin
        i_addr  = $urandom();
        d_addr  = $urandom();
        d_write = !dw;
        d_wdata = $urandom();
      end
    end
    check("i_hold", i_line, m_i_line);
    check("d_hold", d_line, m_d_line);
    $display("txn i=%0d d=%0d ia=%h da=%h wr=%0d wd=%h first=%s scr=%0d",
             ui, ud, ia, da, dw, wd, data_first ? "D" : "I", scramble);
  endtask

  // Data write aborted by reset in cycle k of its transaction.
  task automatic abort_write(input logic [31:0] a, input logic [31:0] wd, input int k);
    logic [127:0] dummy;
    d_req   = 1'b1;
    d_addr  = a;
    d_write = 1'b1;
    d_wdata = wd;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (c < k && c <= LAT) check("abort_dval", {127'd0, d_valid}, 128'd0);
    end
    rstn  = 1'b0;
    d_req = 1'b0;
    #1;
    check_all_zero("abort");
    if (k > LAT) dummy = model_access(a, 1'b1, wd);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    $display("txn abort write a=%h wd=%h cycle=%0d", a, wd, k);
  endtask

  initial begin
    rstn    = 1'b1;
    i_req   = 1'b0;
    i_addr  = 32'd0;
    d_req   = 1'b0;
    d_addr  = 32'd0;
    d_write = 1'b0;
    d_wdata = 32'd0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 128'd0;

    @(negedge clk);
    do_reset();

    // Fill lines 0..15 so every later read has a known expected value.
    for (int ln = 0; ln < 16; ln++) begin
      for (int w = 0; w < 4; w++) begin
        issue(1'b0, 1'b1, 32'd0, 32'(ln * 16 + w * 4), 1'b1, $urandom(), 1'b0);
      end
    end

    // Word write then instruction fill of the same line.
    issue(1'b0, 1'b1, 32'd0, 32'h0000_0014, 1'b1, 32'hDEADBEEF, 1'b0);
    check("deadbeef_d", {96'd0, d_line[63:32]}, {96'd0, 32'hDEADBEEF});
    issue(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'd0, 1'b0);
    check("deadbeef_i", {96'd0, i_line[63:32]}, {96'd0, 32'hDEADBEEF});

    // Tie right after reset goes to data, then round-robin to instruction.
    do_reset();
    issue(1'b1, 1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0, 32'd0, 1'b0);
    issue(1'b1, 1'b1, 32'h0000_0050, 32'h0000_0060, 1'b0, 32'd0, 1'b0);

    // Line index wraps modulo the depth.
    issue(1'b0, 1'b1, 32'd0, 32'h0000_1014, 1'b1, 32'h12345678, 1'b0);
    issue(1'b0, 1'b1, 32'd0, 32'h0000_0014, 1'b0, 32'd0, 1'b0);
    check("wrap", {96'd0, d_line[63:32]}, {96'd0, 32'h12345678});

    // Reset before commit drops the write; reset in RESPOND keeps it.
    issue(1'b0, 1'b1, 32'd0, 32'h0000_0020, 1'b1, 32'hAAAAAAAA, 1'b0);
    abort_write(32'h0000_0020, 32'h55555555, 2);
    issue(1'b0, 1'b1, 32'd0, 32'h0000_0020, 1'b0, 32'd0, 1'b0);
    check("abort_word", {96'd0, d_line[31:0]}, {96'd0, 32'hAAAAAAAA});
    abort_write(32'h0000_0030, 32'h77777777, LAT + 1);
    issue(1'b1, 1'b0, 32'h0000_0030, 32'd0, 1'b0, 32'd0, 1'b0);
    check("commit_word", {96'd0, i_line[31:0]}, {96'd0, 32'h77777777});

    // Inputs changing after the grant are ignored.
    issue(1'b0, 1'b1, 32'd0, 32'h0000_0010, 1'b0, 32'd0, 1'b1);

    // Random mix of reads, writes and ties.
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: issue(1'b1, 1'b0, rand_addr(), 32'd0, 1'b0, 32'd0, ($urandom_range(0, 3) == 0));
        1: issue(1'b0, 1'b1, 32'd0, rand_addr(), 1'b0, 32'd0, ($urandom_range(0, 3) == 0));
        2: issue(1'b0, 1'b1, 32'd0, rand_addr(), 1'b1, $urandom(), ($urandom_range(0, 3) == 0));
        default: issue(1'b1, 1'b1, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                       $urandom(), 1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
